instr_reg_store: RTL and testbench
==================================

// Module: instr_reg_store
// PURPOSE
//  Receiving end of the instr_reg_ifc stimulus protocol: a synthesizable instruction register file.
//  Captures {opcode, operand_a, operand_b} into an addressed entry when load_en is high.
//  Returns the entry at read_pointer as a registered instruction word with valid/miss flags.
//  Sits behind instr_reg_ifc as the DUT that the stimulus driver writes and the monitor checks.
// PARAMETERS
//  NUM_ENTRIES  32  number of register entries; power of 2, >= 2
//  PTR_W        $clog2(NUM_ENTRIES)  pointer width (derived, not overridden)
//  OPERAND_W    32  signed operand width
//  CNT_W        16  width of saturating load counter
// PORTS
//  clk              in   1          single clock; all state updates on rising edge
//  reset            in   1          asynchronous, active-high reset
//  load_en          in   1          write strobe, sampled at rising clk
//  write_pointer    in   PTR_W      entry written when load_en=1
//  read_pointer     in   PTR_W      entry read every cycle
//  operand_a        in   OPERAND_W  signed operand A to store
//  operand_b        in   OPERAND_W  signed operand B to store
//  opcode           in   opcode_t   operation code to store
//  instruction_word out  instr_t    {opc, op_a, op_b} of entry read; 0 when miss
//  rd_valid         out  1          entry read had been loaded since reset
//  rd_miss          out  1          entry read never loaded since reset
//  load_count       out  CNT_W      number of accepted loads, saturating
// BEHAVIOUR
//  Reset: async assert clears the valid vector, instruction_word=0, rd_valid=0, rd_miss=0, load_count=0.
//    Entry data is not reset; it is masked by the valid bits. Deassertion is taken synchronously to clk.
//  Write: rising clk with load_en=1 and reset=0 -> entry[write_pointer] <= {opcode, operand_a, operand_b};
//    valid[write_pointer] <= 1. Overwrite of a valid entry is legal and silent.
//  load_count: +1 per accepted write; holds at 2**CNT_W-1 (no wrap).
//  Read: registered, 1-cycle latency. Outputs after edge N reflect read_pointer sampled at edge N:
//    valid entry -> instruction_word=entry, rd_valid=1, rd_miss=0
//    invalid entry -> instruction_word=0, rd_valid=0, rd_miss=1
//  Read outputs update every cycle, independent of load_en.
//  Collision: load_en=1 with write_pointer==read_pointer at the same edge -> write-first bypass.
//    Outputs show the new data with rd_valid=1, never the stale entry.
//  Inputs are launched 1ns after a rising edge and sampled at the following edge; no combinational in->out path.
//  Reset during operation: a write at an edge where reset is asserted is dropped.
//    All entries read as miss until reloaded.
//  Pointers are exactly PTR_W bits; no out-of-range case exists. opcode is stored unchanged, including unlisted encodings.
// STRUCTURE
//  instr_reg_pkg (shared):
//    opcode_t enum (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD)
//    operand_t signed [OPERAND_W-1:0]
//    pointer_t [PTR_W-1:0]
//    instr_t packed struct {opc, op_a, op_b}
//    NUM_ENTRIES/OPERAND_W defaults as constants
//  Sub-module sat_counter #(CNT_W): enable-driven saturating counter with async active-high reset.
//  Storage: unpacked array of instr_t plus NUM_ENTRIES-bit valid vector; read/bypass mux and output regs in top.
// TESTING
//  1. Assert reset, read ptr 0..31 -> every cycle rd_miss=1, rd_valid=0, instruction_word=0, load_count=0.
//  2. Load wp=5 {ADD,a=7,b=-3}, next cycle rp=5 -> one cycle later instruction_word={ADD,7,-3}, rd_valid=1, load_count=1.
//  3. Same edge: load wp=9 {SUB,100,1} with rp=9 -> next outputs {SUB,100,1}, rd_valid=1 (bypass), never miss.
//  4. Load wp=3 twice ({PASSA,1,2} then {MULT,-4,5}), read rp=3 -> {MULT,-4,5}; load_count=2.
//  5. Load all 32 entries, assert reset asynchronously mid-cycle with load_en=1 -> outputs 0 immediately;
//     after release all reads miss; load_count=0.
//  6. CNT_W=4, 20 consecutive loads -> load_count reaches 15 and holds at 15.

Source files
------------

// File: rtl/instr_reg_store_pkg.sv
// Purpose: shared types and constants for the instruction register store.
//   opcode_t  : 3-bit operation code (all 8 encodings named)
//   operand_t : signed operand
//   pointer_t : entry index
//   instr_t   : packed {opc, op_a, op_b} word held in each entry
package instr_reg_store_pkg;

  localparam int unsigned NUM_ENTRIES   = 32;
  localparam int unsigned PTR_W         = $clog2(NUM_ENTRIES);
  localparam int unsigned OPERAND_W     = 32;
  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned OPC_W         = 3;

  typedef enum logic [OPC_W-1:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic [PTR_W-1:0]            pointer_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instr_t;

  localparam int unsigned INSTR_W = $bits(instr_t);

  // Assemble an instruction word from its fields.
  function automatic instr_t make_instr(input opcode_t opc, input operand_t op_a,
                                        input operand_t op_b);
    instr_t w;
    w.opc  = opc;
    w.op_a = op_a;
    w.op_b = op_b;
    return w;
  endfunction

endpackage

// File: rtl/instr_reg_store_if.sv
// Purpose: bus between the stimulus driver and the instruction register store.
//   Write side : load_en, write_pointer, operand_a, operand_b, opcode
//   Read side  : read_pointer in; instruction_word, rd_valid, rd_miss, load_count out
//   master = driver/monitor, slave = storage block
interface instr_reg_store_if
  import instr_reg_store_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

  logic             load_en;
  pointer_t         write_pointer;
  pointer_t         read_pointer;
  operand_t         operand_a;
  operand_t         operand_b;
  opcode_t          opcode;
  instr_t           instruction_word;
  logic             rd_valid;
  logic             rd_miss;
  logic [CNT_W-1:0] load_count;

  modport master (
    output load_en, write_pointer, read_pointer, operand_a, operand_b, opcode,
    input  instruction_word, rd_valid, rd_miss, load_count
  );

  modport slave (
    input  load_en, write_pointer, read_pointer, operand_a, operand_b, opcode,
    output instruction_word, rd_valid, rd_miss, load_count
  );

endinterface

// File: rtl/instr_reg_store_sat_counter.sv
// Purpose: enable-driven up counter that holds at all-ones instead of wrapping.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears count
//   i_en    : count one event this cycle
//   o_count : registered count value
module instr_reg_store_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {CNT_W{1'b1}});

  // Increment on enable unless already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/instr_reg_store.sv
// Purpose: instruction register file; writes {opcode, operand_a, operand_b} into
//   an addressed entry and returns the entry at read_pointer one cycle later.
//   clk   : clock, all state updates on rising edge
//   reset : asynchronous active-high reset (clears valid bits and outputs)
//   ifc   : slave side of instr_reg_store_if
//     in  load_en, write_pointer, read_pointer, operand_a, operand_b, opcode
//     out instruction_word (0 on miss), rd_valid, rd_miss, load_count (saturating)
module instr_reg_store
  import instr_reg_store_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  instr_reg_store_if.slave   ifc
);

  instr_t                 r_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_valid;
  instr_t                 r_instr;
  logic                   r_rd_valid;
  logic                   r_rd_miss;

  instr_t                 w_new;
  logic                   w_bypass;
  instr_t                 w_rd_instr;
  logic                   w_rd_valid;
  logic                   w_rd_miss;
  logic [CNT_W-1:0]       w_count;

  assign w_new    = make_instr(ifc.opcode, ifc.operand_a, ifc.operand_b);
  assign w_bypass = ifc.load_en && (ifc.write_pointer == ifc.read_pointer);

  // Entry data is not reset; stale contents are hidden by r_valid.
  // The reset term drops a write coinciding with an asserted reset.
  always_ff @(posedge clk) begin
    if (ifc.load_en && !reset) begin
      r_mem[ifc.write_pointer] <= w_new;
    end
  end

  // Loaded-since-reset flag per entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (ifc.load_en) begin
      r_valid[ifc.write_pointer] <= 1'b1;
    end
  end

  // Read select: a same-edge write to the read entry wins over stored contents.
  always_comb begin
    w_rd_instr = '0;
    w_rd_valid = 1'b0;
    w_rd_miss  = 1'b1;
    if (w_bypass) begin
      w_rd_instr = w_new;
      w_rd_valid = 1'b1;
      w_rd_miss  = 1'b0;
    end else if (r_valid[ifc.read_pointer]) begin
      w_rd_instr = r_mem[ifc.read_pointer];
      w_rd_valid = 1'b1;
      w_rd_miss  = 1'b0;
    end
  end

  // Registered read port, refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_miss  <= 1'b0;
    end else begin
      r_instr    <= w_rd_instr;
      r_rd_valid <= w_rd_valid;
      r_rd_miss  <= w_rd_miss;
    end
  end

  instr_reg_store_sat_counter #(
    .CNT_W (CNT_W)
  ) u_load_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_en    (ifc.load_en),
    .o_count (w_count)
  );

  assign ifc.instruction_word = r_instr;
  assign ifc.rd_valid         = r_rd_valid;
  assign ifc.rd_miss          = r_rd_miss;
  assign ifc.load_count       = w_count;

endmodule

// File: tb/tb_instr_reg_store.sv
// Purpose: directed, scoreboard-checked bench for instr_reg_store. Two instances
//   share one stimulus stream: the default 16-bit load counter and a 4-bit one.
module tb_instr_reg_store;
  import instr_reg_store_pkg::*;

  typedef struct {
    instr_t      w;
    logic        v;
    logic        m;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  logic clk;
  logic rst_v;
  int   checks;
  int   failures;

  exp_t sb [$];

  instr_t      m_mem [NUM_ENTRIES];
  logic        m_vld [NUM_ENTRIES];
  logic [15:0] m_c16;
  logic [3:0]  m_c4;

  instr_reg_store_if #(.CNT_W(16)) u_if  ();
  instr_reg_store_if #(.CNT_W(4))  u_if4 ();

  assign u_if4.load_en       = u_if.load_en;
  assign u_if4.write_pointer = u_if.write_pointer;
  assign u_if4.read_pointer  = u_if.read_pointer;
  assign u_if4.operand_a     = u_if.operand_a;
  assign u_if4.operand_b     = u_if.operand_b;
  assign u_if4.opcode        = u_if.opcode;

  instr_reg_store #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (rst_v),
    .ifc   (u_if)
  );

  instr_reg_store #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (rst_v),
    .ifc   (u_if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [INSTR_W-1:0] obs,
                     input logic [INSTR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NUM_ENTRIES); i++) m_vld[i] = 1'b0;
    m_c16 = '0;
    m_c4  = '0;
  endtask

  // Drive one cycle of stimulus, push the expected read result, then compare it
  // against the outputs sampled 1ns after the capturing edge.
  task automatic step(input string tag, input logic le, input pointer_t wp,
                      input pointer_t rp, input opcode_t o, input operand_t a,
                      input operand_t b);
    exp_t   e;
    instr_t n;
    n = make_instr(o, a, b);
    u_if.load_en       = le;
    u_if.write_pointer = wp;
    u_if.read_pointer  = rp;
    u_if.opcode        = o;
    u_if.operand_a     = a;
    u_if.operand_b     = b;
    e.w = '0;
    e.v = 1'b0;
    e.m = 1'b0;
    if (rst_v) begin
      model_clear();
    end else begin
      if (le && wp == rp) begin
        e.w = n; e.v = 1'b1; e.m = 1'b0;
      end else if (m_vld[rp]) begin
        e.w = m_mem[rp]; e.v = 1'b1; e.m = 1'b0;
      end else begin
        e.w = '0; e.v = 1'b0; e.m = 1'b1;
      end
      if (le) begin
        m_mem[wp] = n;
        m_vld[wp] = 1'b1;
        if (m_c16 != 16'hFFFF) m_c16 = m_c16 + 16'd1;
        if (m_c4 != 4'hF)      m_c4  = m_c4 + 4'd1;
      end
    end
    e.c16 = m_c16;
    e.c4  = m_c4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_word"},  INSTR_W'(u_if.instruction_word), INSTR_W'(e.w));
      chk({tag, "_valid"}, INSTR_W'(u_if.rd_valid),         INSTR_W'(e.v));
      chk({tag, "_miss"},  INSTR_W'(u_if.rd_miss),          INSTR_W'(e.m));
      chk({tag, "_cnt16"}, INSTR_W'(u_if.load_count),       INSTR_W'(e.c16));
      chk({tag, "_cnt4"},  INSTR_W'(u_if4.load_count),      INSTR_W'(e.c4));
    end
  endtask

  task automatic rd(input string tag, input pointer_t rp);
    step(tag, 1'b0, '0, rp, ZERO, '0, '0);
  endtask

  task automatic sync_reset();
    rst_v = 1'b1;
    step("rst", 1'b0, '0, '0, ZERO, '0, '0);
    rst_v = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_v    = 1'b1;
    model_clear();
    u_if.load_en       = 1'b0;
    u_if.write_pointer = '0;
    u_if.read_pointer  = '0;
    u_if.opcode        = ZERO;
    u_if.operand_a     = '0;
    u_if.operand_b     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word",  INSTR_W'(u_if.instruction_word), '0);
    chk("rst_valid", INSTR_W'(u_if.rd_valid),         '0);
    chk("rst_miss",  INSTR_W'(u_if.rd_miss),          '0);
    chk("rst_cnt",   INSTR_W'(u_if.load_count),       '0);
    step("rst_hold", 1'b0, '0, 5'd3, ZERO, '0, '0);
    rst_v = 1'b0;

    // Every entry misses after reset
    for (int i = 0; i < int'(NUM_ENTRIES); i++) rd("t1_miss", pointer_t'(i));

    // Load then read back
    step("t2_load", 1'b1, 5'd5, 5'd0, ADD, 32'sd7, -32'sd3);
    rd("t2_read", 5'd5);

    // Same-edge write/read bypass
    step("t3_bypass", 1'b1, 5'd9, 5'd9, SUB, 32'sd100, 32'sd1);
    rd("t3_after", 5'd9);

    // Overwrite of a valid entry
    sync_reset();
    step("t4_first",  1'b1, 5'd3, 5'd5, PASSA, 32'sd1, 32'sd2);
    step("t4_second", 1'b1, 5'd3, 5'd0, MULT, -32'sd4, 32'sd5);
    rd("t4_read", 5'd3);

    // Fill every entry, then async reset mid-cycle with a write pending
    for (int i = 0; i < int'(NUM_ENTRIES); i++)
      step("t5_fill", 1'b1, pointer_t'(i), pointer_t'(i + 31), opcode_t'(i % 8),
           operand_t'($urandom), operand_t'($urandom));
    rd("t5_chk", 5'd17);
    u_if.load_en       = 1'b1;
    u_if.write_pointer = 5'd7;
    u_if.read_pointer  = 5'd7;
    #3;
    rst_v = 1'b1;
    #1;
    chk("t5_async_word",  INSTR_W'(u_if.instruction_word), '0);
    chk("t5_async_valid", INSTR_W'(u_if.rd_valid),         '0);
    chk("t5_async_miss",  INSTR_W'(u_if.rd_miss),          '0);
    chk("t5_async_cnt",   INSTR_W'(u_if.load_count),       '0);
    step("t5_drop", 1'b1, 5'd7, 5'd7, DIV, 32'sd11, 32'sd12);
    rst_v = 1'b0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) rd("t5_miss", pointer_t'(i));

    // Counter saturation: 4-bit instance holds at 15
    for (int i = 0; i < 20; i++)
      step("t6_sat", 1'b1, pointer_t'($urandom), pointer_t'($urandom), MOD,
           operand_t'(i), -operand_t'(i));
    rd("t6_hold", 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
